// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage CPU pipeline.
// Holds the NOP word, PC step and the IF/ID bundle.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    localparam if_id_t IFID_BUBBLE = '{
        pc4:   32'h0,
        instr: NOP_INSTR,
        valid: 1'b0
    };

endpackage

// File: rtl/pc_reg.sv
// Program counter flop with async reset.
// Load wins over hold; otherwise the PC steps by one word.
import cpu_pkg::*;

module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hold_i,
    input  logic        load_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_o <= RESET_PC;
        end else if (load_i) begin
            pc_o <= target_i;
        end else if (!hold_i) begin
            pc_o <= pc_o + PC_STEP;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem address and IF/ID register.
// Define IF_PERF_CNT_EN to add stall/flush event counters.
import cpu_pkg::*;

module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    logic        do_flush;
    logic        do_stall;
    logic        in_range;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] target;
    logic [31:0] fetched;
    logic        unused_bits;
    if_id_t      ifid_q;
    if_id_t      ifid_d;

    assign do_flush = start_i & flush_i;
    assign do_stall = start_i & stall_i & ~flush_i;
    assign target   = {redirect_pc_i[31:2], 2'b00};
    assign unused_bits = ^redirect_pc_i[1:0];

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hold_i   (~start_i | do_stall),
        .load_i   (do_flush),
        .target_i (target),
        .pc_o     (pc)
    );

    assign pc4      = pc + PC_STEP;
    assign in_range = {2'b00, pc[31:2]} < 32'(IMEM_WORDS);
    assign fetched  = in_range ? imem_data_i : NOP_INSTR;

    always_comb begin
        ifid_d = ifid_q;
        unique case (1'b1)
            (!start_i || do_flush): ifid_d = IFID_BUBBLE;
            do_stall:               ifid_d = ifid_q;
            default: begin
                ifid_d.pc4   = pc4;
                ifid_d.instr = fetched;
                ifid_d.valid = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ifid_q <= IFID_BUBBLE;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign pc_o         = pc;
    assign imem_addr_o  = pc;
    assign ifid_pc4_o   = ifid_q.pc4;
    assign ifid_instr_o = ifid_q.instr;
    assign ifid_valid_o = ifid_q.valid;

`ifdef IF_PERF_CNT_EN
    // Counters saturate rather than wrap so long runs stay monotonic.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (do_stall && stall_cnt_o != '1) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (do_flush && flush_cnt_o != '1) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small imem model.
// Counter checks are built only with IF_PERF_CNT_EN.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stall;
    logic        flush;
    logic [31:0] redirect;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    if_stage #(
        .RESET_PC   (32'h0),
        .IMEM_WORDS (256)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .stall_i       (stall),
        .flush_i       (flush),
        .redirect_pc_i (redirect),
        .imem_addr_o   (imem_addr),
        .imem_data_i   (imem_data),
        .pc_o          (pc),
        .ifid_pc4_o    (pc4),
        .ifid_instr_o  (instr),
        .ifid_valid_o  (valid)
`ifdef IF_PERF_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt),
        .flush_cnt_o   (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    // Out-of-range reads return garbage the DUT must replace with NOP.
    always_comb begin
        if (imem_addr[31:10] == 22'h0) imem_data = word(int'(imem_addr[9:2]));
        else imem_data = 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] e_pc,
                            input logic [31:0] e_pc4, input logic [31:0] e_ins,
                            input logic e_v);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".addr"}, imem_addr, e_pc);
        check({tag, ".pc4"}, pc4, e_pc4);
        check({tag, ".instr"}, instr, e_ins);
        check({tag, ".valid"}, {31'b0, valid}, {31'b0, e_v});
    endtask

    task automatic chk_cnt(input string tag, input int s, input int f);
`ifdef IF_PERF_CNT_EN
        check({tag, ".scnt"}, stall_cnt, 32'(s));
        check({tag, ".fcnt"}, flush_cnt, 32'(f));
`else
        if (tag.len() < 0) $display("%0d %0d", s, f);
`endif
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        redirect = 32'h0;
        #12;
        chk_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        chk_cnt("reset", 0, 0);
        rst = 1'b0;
        start = 1'b1;

        step(); chk_ifid("run1", 32'h4, 32'h4, word(0), 1'b1);
        step(); chk_ifid("run2", 32'h8, 32'h8, word(1), 1'b1);
        step(); chk_ifid("run3", 32'hC, 32'hC, word(2), 1'b1);

        stall = 1'b1;
        step(); chk_ifid("stall1", 32'hC, 32'hC, word(2), 1'b1);
        step(); chk_ifid("stall2", 32'hC, 32'hC, word(2), 1'b1);
        chk_cnt("stall", 2, 0);
        stall = 1'b0;
        step(); chk_ifid("run4", 32'h10, 32'h10, word(3), 1'b1);

        flush = 1'b1;
        redirect = 32'h40;
        step(); chk_ifid("flush", 32'h40, 32'h0, 32'h0, 1'b0);
        chk_cnt("flush", 2, 1);
        flush = 1'b0;
        step(); chk_ifid("tgt", 32'h44, 32'h44, word(16), 1'b1);

        stall = 1'b1;
        flush = 1'b1;
        redirect = 32'h23;
        step(); chk_ifid("sf", 32'h20, 32'h0, 32'h0, 1'b0);
        chk_cnt("sf", 2, 2);
        stall = 1'b0;
        flush = 1'b0;
        step(); chk_ifid("sf_tgt", 32'h24, 32'h24, word(8), 1'b1);

        flush = 1'b1;
        redirect = 32'h3FC;
        step(); chk_ifid("to_edge", 32'h3FC, 32'h0, 32'h0, 1'b0);
        flush = 1'b0;
        step(); chk_ifid("last", 32'h400, 32'h400, word(255), 1'b1);
        step(); chk_ifid("oor", 32'h404, 32'h404, 32'h0, 1'b1);

        flush = 1'b1;
        redirect = 32'hFFFF_FFFC;
        step(); chk_ifid("to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        flush = 1'b0;
        step(); chk_ifid("wrap", 32'h0, 32'h0, 32'h0, 1'b1);
        step(); chk_ifid("run5", 32'h4, 32'h4, word(0), 1'b1);
        chk_cnt("pre_idle", 2, 4);

        start = 1'b0;
        stall = 1'b1;
        step(); chk_ifid("idle1", 32'h4, 32'h0, 32'h0, 1'b0);
        step(); chk_ifid("idle2", 32'h4, 32'h0, 32'h0, 1'b0);
        chk_cnt("idle", 2, 4);
        stall = 1'b0;
        start = 1'b1;
        step(); chk_ifid("run6", 32'h8, 32'h8, word(1), 1'b1);

        #3 rst = 1'b1;
        #1;
        chk_ifid("arst", 32'h0, 32'h0, 32'h0, 1'b0);
        chk_cnt("arst", 0, 0);
        #10 rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
